spart_tx: RTL

SPART_TX -- requirements
Module: spart_tx

---
 rtl/spart_pkg.sv | 19 +
 rtl/spart_tx.sv | 122 ++++++++++++
 2 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART transmitter: state encoding,
// default frame geometry and the serial line levels.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/spart_tx.sv
// SPART serial transmitter: one-deep holding buffer feeding an 8N1
// shift path, bit timing derived from the oversample enable strobe.
module spart_tx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_load,
  output logic                 tbr,
  output logic                 tx_busy,
  output logic                 txd
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_full;
  logic                 bit_end;

  assign bit_end    = enable && (tick_cnt == TICK_LAST);
  assign shift_next = shift >> 1;
  assign tbr        = ~hold_full;
  assign tx_busy    = (state != IDLE);

  // Loads and transfers never collide: a load needs an empty buffer,
  // a transfer needs a full one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      txd       <= LINE_IDLE;
    end else begin
      if (tx_load && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (hold_full) begin
            shift     <= hold_data;
            hold_full <= 1'b0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            txd       <= LINE_START;
            state     <= START;
          end
        end

        START: begin
          if (bit_end) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shift[0];
            state    <= DATA;
          end else if (enable) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              txd   <= LINE_STOP;
              state <= STOP;
            end else begin
              shift   <= shift_next;
              txd     <= shift_next[0];
              bit_idx <= bit_idx + 1'b1;
            end
          end else if (enable) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            // A waiting byte starts immediately so back-to-back frames
            // have no idle gap on the line.
            if (hold_full) begin
              shift     <= hold_data;
              hold_full <= 1'b0;
              txd       <= LINE_START;
              state     <= START;
            end else begin
              txd   <= LINE_IDLE;
              state <= IDLE;
            end
          end else if (enable) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: begin
          txd   <= LINE_IDLE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
